textmem_arb: RTL
================

TEXTMEM_ARB -- requirements
Module: textmem_arb

Interface
REQ-001 Parameter AWIDTH, default 12: word-address width of the text RAM (4096 x 32 bit).
REQ-002 Parameter INITNAME, default "rtl/textmem.mif": RAM initialisation file.
REQ-003 clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous assert, active-low (0 = reset).
REQ-005 vbus  if_wb.slave  32-bit data  video fetch port; the text driver is the master.
REQ-006 cbus  if_wb.slave  32-bit data  CPU port; read/write, byte lanes via sel.
REQ-007 Each wishbone port carries cyc, stb, we, sel[3:0], adr[31:0], dat (both directions), ack and stall.

Function
REQ-008 Word address on each port SHALL be adr[AWIDTH+1:2]; higher bits ignored, so addresses wrap modulo 2^AWIDTH words.
REQ-009 Video port SHALL never stall (vbus.stall = 0) and SHALL accept one request on every cycle with vbus.cyc & vbus.stb.
REQ-010 Video read SHALL be acked exactly 2 cycles after acceptance, with vbus read data valid in the same cycle as the ack; back-to-back requests give back-to-back acks in order.
REQ-011 Video requests with we = 1 SHALL be acked per REQ-010 but SHALL NOT modify RAM; read data returns 0.
REQ-012 Video ack pipeline (2-deep valid shift register) SHALL be cleared on any cycle vbus.cyc = 0; no ack is issued for abandoned requests.
REQ-013 Video has absolute priority for the RAM port; a CPU request is accepted only in a cycle with no video stb.
REQ-014 cbus.stall SHALL be 1 whenever vbus.cyc & vbus.stb is 1 or the CPU FSM is not in C_IDLE; otherwise 0.
REQ-015 CPU FSM states: C_IDLE, C_RD1, C_RD2, C_WACK.
REQ-016 C_IDLE: accepted write -> RAM write with byte enables = sel -> C_WACK; accepted read -> RAM read issued -> C_RD1; else stay.
REQ-017 C_WACK: cbus.ack = 1 for one cycle -> C_IDLE (write latency 1 cycle after acceptance).
REQ-018 C_RD1 -> C_RD2 unconditionally; C_RD2: cbus.ack = 1 with registered read data -> C_IDLE (read latency 2 cycles after acceptance).
REQ-019 If cbus.cyc drops in C_RD1/C_RD2/C_WACK, the FSM SHALL return to C_IDLE without ack; a write already issued to RAM stays committed.
REQ-020 A read following a write to the same address (either port) SHALL return the written data.
REQ-021 ack on either port SHALL never be 1 while that port's cyc is 0.

Reset
REQ-022 While rst_i = 0: vbus.ack = 0, cbus.ack = 0, cbus.stall = 0, both read-data registers = 32'h0, FSM = C_IDLE, video valid pipeline = 0.
REQ-023 Reset asserted mid-transaction SHALL drop all pending acks; RAM contents are not reset.
REQ-024 Release of rst_i is synchronised internally (2-flop) so the first accept occurs no earlier than the 2nd clock after deassertion.

Structure
REQ-025 Package textmem_pkg holds cstate_t (C_IDLE, C_RD1, C_RD2, C_WACK), VID_LAT = 2, TEXT_WORDS = 2500 (50 words x 50 rows).
REQ-026 One sub-module spram_be: single-port RAM, byte-enabled write, registered read, AWIDTH/DWIDTH/INITNAME parameters; no reset on the array.

Verification
REQ-027 Video burst of 50 reads at 0x0..0xC4 (stb every cycle) -> 50 acks in cycles 2..51 after first stb, data = preloaded words in order, no gaps.
REQ-028 CPU write 0x41_07_42_07 to word 5 with sel = 4'hf, then CPU read word 5 -> write ack 1 cycle after accept, read ack 2 cycles after accept, data 0x41074207.
REQ-029 CPU read and video read asserted in the same cycle -> video acked after 2 cycles; cbus.stall = 1 until video stb drops, CPU acked 2 cycles after its acceptance.
REQ-030 CPU write sel = 4'b0010 data 0xFFFFFFFF over word 0x00000000 -> subsequent read returns 0x0000FF00.
REQ-031 vbus.cyc dropped 1 cycle after a video stb -> no vbus.ack issued; address 0x4000 + 8 read -> returns word 2 (wrap).
REQ-032 rst_i pulled low during C_RD1 -> cbus.ack stays 0, FSM in C_IDLE, stall 0 after release.

Source files
------------

// File: rtl/textmem_pkg.sv
// Shared types and constants for the text-memory arbiter.
package textmem_pkg;

  typedef enum logic [1:0] {
    C_IDLE,
    C_RD1,
    C_RD2,
    C_WACK
  } cstate_t;

  // Video read latency in cycles from acceptance to ack.
  localparam int VID_LAT = 2;

  // Visible text area: 50 words per row, 50 rows.
  localparam int TEXT_WORDS = 2500;

endpackage

// File: rtl/textmem_arb_if.sv
// Pipelined wishbone-style bus used by the video and CPU ports of the text RAM.
interface if_wb;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, stall
  );

endinterface

// File: rtl/textmem_arb_spram.sv
// Single-port RAM with per-byte write enables and a registered read port.
// The array is deliberately not reset so contents survive a system reset.
module spram_be #(
  parameter int    AWIDTH   = 12,
  parameter int    DWIDTH   = 32,
  parameter string INITNAME = ""
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [DWIDTH/8-1:0]   be,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH-1:0]     wdata,
  output logic [DWIDTH-1:0]     rdata
);

  localparam int NBYTES = DWIDTH / 8;

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // Byte-masked write and read-before-write registered read on every clock.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (we && be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/textmem_arb.sv
// Text RAM arbiter: a never-stalling video fetch port with fixed 2-cycle read
// latency, and a CPU read/write port that only gets the RAM when video is idle.
module textmem_arb
  import textmem_pkg::*;
#(
  parameter int    AWIDTH   = 12,
  parameter string INITNAME = "rtl/textmem.mif"
) (
  input  logic clk_i,
  input  logic rst_i,
  if_wb.slave  vbus,
  if_wb.slave  cbus
);

  logic [1:0]         rst_sync;
  logic               rst_n_int;
  logic               vid_req;
  logic               cpu_req;
  logic [VID_LAT-1:0] vid_vld;
  logic [VID_LAT-1:0] vid_we;
  logic [31:0]        vid_dat;
  logic [31:0]        cpu_dat;
  cstate_t            state;
  cstate_t            state_nxt;
  logic [AWIDTH-1:0]  ram_addr;
  logic               ram_we;
  logic [3:0]         ram_be;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;
  logic               unused_bits;

  // Reset asserts immediately but releases two clocks after rst_i rises.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  assign vid_req = vbus.cyc & vbus.stb;
  assign cpu_req = cbus.cyc & cbus.stb & (state == C_IDLE) & ~vid_req & rst_n_int;

  // RAM port mux: video always wins; video never writes.
  always_comb begin
    ram_addr  = vbus.adr[AWIDTH+1:2];
    ram_we    = 1'b0;
    ram_be    = cbus.sel;
    ram_wdata = cbus.dat_w;
    if (!vid_req) begin
      ram_addr = cbus.adr[AWIDTH+1:2];
      ram_we   = cpu_req & cbus.we;
    end
  end

  spram_be #(
    .AWIDTH   (AWIDTH),
    .DWIDTH   (32),
    .INITNAME (INITNAME)
  ) u_ram (
    .clk_i (clk_i),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Video ack pipeline; an abandoned cycle flushes every in-flight request.
  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      vid_vld <= '0;
      vid_we  <= '0;
      vid_dat <= 32'h0;
    end else begin
      if (!vbus.cyc) begin
        vid_vld <= '0;
        vid_we  <= '0;
      end else begin
        vid_vld <= {vid_vld[VID_LAT-2:0], vid_req};
        vid_we  <= {vid_we[VID_LAT-2:0], vbus.we};
      end
      if (vid_vld[0]) begin
        vid_dat <= vid_we[0] ? 32'h0 : ram_rdata;
      end
    end
  end

  assign vbus.ack   = vbus.cyc & vid_vld[VID_LAT-1];
  assign vbus.dat_r = vid_dat;
  assign vbus.stall = 1'b0;

  // CPU state register and read-data capture one cycle after the RAM read.
  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state   <= C_IDLE;
      cpu_dat <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == C_RD1) begin
        cpu_dat <= ram_rdata;
      end
    end
  end

  // CPU next-state: any dropped cyc abandons the transfer without an ack.
  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE: begin
        if (cpu_req) begin
          state_nxt = cbus.we ? C_WACK : C_RD1;
        end
      end
      C_RD1:   state_nxt = cbus.cyc ? C_RD2 : C_IDLE;
      C_RD2:   state_nxt = C_IDLE;
      C_WACK:  state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  assign cbus.ack   = cbus.cyc & ((state == C_RD2) | (state == C_WACK));
  assign cbus.dat_r = cpu_dat;
  assign cbus.stall = rst_i & (~rst_n_int | vid_req | (state != C_IDLE));

  assign unused_bits = ^{vbus.sel, vbus.dat_w, vbus.adr[31:AWIDTH+2], vbus.adr[1:0],
                         cbus.adr[31:AWIDTH+2], cbus.adr[1:0]};

endmodule
